// File: rtl/efpga_op_unit.sv
// Behavioural eFPGA custom-operation engine: add/sub, iterative multiply, logic and
// bit-manipulation ops with a programmable post-calculation wait and a done pulse.
module efpga_op_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DELAY_W    = 4,
    parameter int unsigned MUL_ENABLE = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               write_strobe_i,
    input  logic [1:0]         operator_i,
    input  logic [DELAY_W-1:0] delay_i,
    input  logic [WIDTH-1:0]   operand_a_i,
    input  logic [WIDTH-1:0]   operand_b_i,
    output logic [WIDTH-1:0]   result_a_o,
    output logic [WIDTH-1:0]   result_b_o,
    output logic [WIDTH-1:0]   result_c_o,
    output logic               fpga_done_o,
    output logic               busy_o,
    output logic               overrun_o
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned POP_W  = 6;
    localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [DELAY_W-1:0] DLY_ONE   = DELAY_W'(1);
    localparam logic [1:0]         OP_MUL    = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_op;
    logic [DELAY_W-1:0]  r_delay;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [PROD_W-1:0]   r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [PROD_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_iter;
    logic [WIDTH-1:0]    r_res_a;
    logic [WIDTH-1:0]    r_res_b;
    logic [WIDTH-1:0]    r_res_c;
    logic                r_done;
    logic                r_busy;
    logic                r_overrun;

    logic                w_accept;
    logic                w_is_mul;
    logic                w_calc_last;
    logic                w_wr_res;
    logic                w_done_nxt;
    logic                w_busy_nxt;
    logic [PROD_W-1:0]   w_prod;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH-1:0]    w_rev;
    logic [WIDTH-1:0]    w_swap;
    logic [WIDTH-1:0]    w_xor;
    logic [POP_W-1:0]    w_pop;
    logic [WIDTH-1:0]    w_res_a;
    logic [WIDTH-1:0]    w_res_b;
    logic [WIDTH-1:0]    w_res_c;

    assign w_accept    = (r_state == S_IDLE) && en_i && write_strobe_i;
    assign w_is_mul    = (r_op == OP_MUL) && (MUL_ENABLE != 0);
    assign w_calc_last = (r_state == S_CALC) && (!w_is_mul || (r_iter == LAST_ITER));
    assign w_prod      = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping en_i during CALC/WAIT aborts without a done pulse.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_CALC;
            S_CALC: begin
                if (!en_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_calc_last) begin
                    w_state_nxt = (r_delay != '0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (!en_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_delay == DLY_ONE) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_done_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        w_wr_res   = 1'b0;
        w_done_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_wr_res   = w_calc_last && en_i;
    end

    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, r_b};
        w_xor  = r_a ^ r_b;
        w_rev  = '0;
        w_swap = '0;
        w_pop  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_rev[i] = r_a[int'(WIDTH) - 1 - i];
            w_pop    = w_pop + POP_W'(w_xor[i]);
        end
        for (int i = 0; i < int'(WIDTH / 8); i++) begin
            w_swap[8*i +: 8] = r_b[int'(WIDTH) - 8 - 8*i +: 8];
        end
    end

    always_comb begin
        w_res_a = '0;
        w_res_b = '0;
        w_res_c = '0;
        case (r_op)
            2'd0: begin
                w_res_a = w_sum[WIDTH-1:0];
                w_res_b = r_a - r_b;
                w_res_c = WIDTH'(w_sum[WIDTH]);
            end
            2'd1: begin
                if (MUL_ENABLE != 0) begin
                    w_res_a = w_prod[WIDTH-1:0];
                    w_res_b = w_prod[PROD_W-1:WIDTH];
                end
            end
            2'd2: begin
                w_res_a = r_a & r_b;
                w_res_b = r_a | r_b;
                w_res_c = w_xor;
            end
            default: begin
                w_res_a = w_rev;
                w_res_b = w_swap;
                w_res_c = WIDTH'(w_pop);
            end
        endcase
    end

    // Operand latch, shift-add multiplier, wait counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_op      <= '0;
            r_delay   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_iter    <= '0;
            r_res_a   <= '0;
            r_res_b   <= '0;
            r_res_c   <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
            r_overrun <= write_strobe_i && (r_state != S_IDLE);
            if (w_accept) begin
                r_op     <= operator_i;
                r_delay  <= delay_i;
                r_a      <= operand_a_i;
                r_b      <= operand_b_i;
                r_mcand  <= PROD_W'(operand_a_i);
                r_mplier <= operand_b_i;
                r_acc    <= '0;
                r_iter   <= '0;
            end else if (r_state == S_CALC) begin
                r_acc    <= w_prod;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_iter   <= r_iter + CNT_W'(1);
            end else if (r_state == S_WAIT) begin
                r_delay  <= r_delay - DLY_ONE;
            end
            if (w_wr_res) begin
                r_res_a <= w_res_a;
                r_res_b <= w_res_b;
                r_res_c <= w_res_c;
            end
        end
    end

    assign result_a_o  = r_res_a;
    assign result_b_o  = r_res_b;
    assign result_c_o  = r_res_c;
    assign fpga_done_o = r_done;
    assign busy_o      = r_busy;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_efpga_op_unit.sv
// Scoreboard bench for efpga_op_unit: randomized ops against an arithmetic reference
// model, plus directed overrun, abort and mid-operation reset scenarios.
module tb_efpga_op_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        strobe = 1'b0;
    logic [1:0]  opi = '0;
    logic [3:0]  dly = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] res_a, res_b, res_c;
    logic        done, busy, ovr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    bit          ovr_exp[int];
    logic [31:0] last_a = '0, last_b = '0, last_c = '0;

    efpga_op_unit dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .write_strobe_i (strobe),
        .operator_i     (opi),
        .delay_i        (dly),
        .operand_a_i    (op_a),
        .operand_b_i    (op_b),
        .result_a_o     (res_a),
        .result_b_o     (res_b),
        .result_c_o     (res_c),
        .fpga_done_o    (done),
        .busy_o         (busy),
        .overrun_o      (ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference behaviour straight from the operation definitions.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ra, output logic [31:0] rb, output logic [31:0] rc);
        longint unsigned pa, pb, p;
        longint unsigned s;
        pa = a; pb = b;
        ra = '0; rb = '0; rc = '0;
        case (op)
            2'd0: begin
                s  = pa + pb;
                ra = a + b;
                rb = a - b;
                rc = (s >= 64'h1_0000_0000) ? 32'd1 : 32'd0;
            end
            2'd1: begin
                p  = pa * pb;
                ra = p[31:0];
                rb = p[63:32];
            end
            2'd2: begin
                ra = a & b; rb = a | b; rc = a ^ b;
            end
            default: begin
                for (int i = 0; i < 32; i++) ra[i] = a[31 - i];
                rb = {b[7:0], b[15:8], b[23:16], b[31:24]};
                rc = 32'($countones(a ^ b));
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one accepted op and keep en high through its busy window, optionally
    // poking strobes (which must produce overrun pulses and be ignored).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] d, input int ovr_at, input bit rand_ovr);
        int   c0, lat;
        exp_t e;
        @(negedge clk);
        en = 1'b1; strobe = 1'b1; opi = op; dly = d; op_a = a; op_b = b;
        c0  = cyc;
        lat = (op == 2'd1) ? 33 + int'(d) : 2 + int'(d);
        model(op, a, b, e.a, e.b, e.c);
        e.cyc = c0 + lat;
        sb.push_back(e);
        last_a = e.a; last_b = e.b; last_c = e.c;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            dly  = 4'($urandom);
            op_a = $urandom;
            op_b = $urandom;
            opi  = 2'($urandom);
            strobe = (k == ovr_at) || (rand_ovr && ($urandom_range(0, 5) == 0));
            if (strobe) ovr_exp[cyc + 1] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en     = 1'($urandom);
            strobe = !en && ($urandom_range(0, 1) == 1);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            chk("done_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("result_a", 64'(res_a), 64'(mon_e.a));
                chk("result_b", 64'(res_b), 64'(mon_e.b));
                chk("result_c", 64'(res_c), 64'(mon_e.c));
            end
        end
        if (ovr || ovr_exp.exists(cyc)) chk("overrun", 64'(ovr), 64'(ovr_exp.exists(cyc)));
    end

    initial begin
        int c0;
        repeat (2) @(negedge clk);
        chk("rst_a", 64'(res_a), 64'd0);
        chk("rst_b", 64'(res_b), 64'd0);
        chk("rst_c", 64'(res_c), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(ovr), 64'd0);
        rst_n = 1'b1;

        issue(2'd0, 32'hFFFF_FFFF, 32'h1, 4'd0, 0, 1'b0);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 0, 1'b0);
        issue(2'd3, 32'h1, 32'h1122_3344, 4'd5, 0, 1'b0);
        issue(2'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd4, 3, 1'b0);
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, 4'd15, 0, 1'b0);

        repeat (40) begin
            idle($urandom_range(0, 2));
            issue(2'($urandom), pick(), pick(), 4'($urandom), 0, 1'b1);
        end

        // Abort a multiply by dropping en_i in CALC: no done, results held.
        idle(1);
        @(negedge clk);
        en = 1'b1; strobe = 1'b1; opi = 2'd1; dly = 4'd2; op_a = $urandom; op_b = $urandom;
        repeat (9) begin
            @(negedge clk);
            strobe = 1'b0;
        end
        @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'd1);
        en = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", 64'(busy), 64'd0);
        chk("abort_hold_a", 64'(res_a), 64'(last_a));
        chk("abort_hold_b", 64'(res_b), 64'(last_b));
        chk("abort_hold_c", 64'(res_c), 64'(last_c));
        repeat (40) @(negedge clk);

        // Reset while waiting: everything clears, nothing completes.
        @(negedge clk);
        en = 1'b1; strobe = 1'b1; opi = 2'd0; dly = 4'd10; op_a = 32'h1234_5678; op_b = 32'h1111_1111;
        c0 = cyc;
        repeat (3) begin
            @(negedge clk);
            strobe = 1'b0;
        end
        @(negedge clk);
        chk("wait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_a", 64'(res_a), 64'd0);
        chk("mid_rst_b", 64'(res_b), 64'd0);
        chk("mid_rst_c", 64'(res_c), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_cycle", 64'(cyc - c0), 64'd5);
        repeat (15) @(negedge clk);

        issue(2'd2, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 4'd1, 0, 1'b1);
        @(negedge clk);
        strobe = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
